// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480 timing, sync-polarity constants and the colour-bar table.
// Shared by vga_axis_counter and vga_timing_gen (pattern enabled by VGA_PATTERN_EN).
package vga_pkg;

    localparam int unsigned VGA_640X480_H_VIS  = 640;
    localparam int unsigned VGA_640X480_H_FP   = 16;
    localparam int unsigned VGA_640X480_H_SYNC = 96;
    localparam int unsigned VGA_640X480_H_BP   = 48;
    localparam int unsigned VGA_640X480_V_VIS  = 480;
    localparam int unsigned VGA_640X480_V_FP   = 10;
    localparam int unsigned VGA_640X480_V_SYNC = 2;
    localparam int unsigned VGA_640X480_V_BP   = 33;
    localparam int unsigned VGA_DEFAULT_CW     = 11;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    typedef enum logic [2:0] {
        RGB_BLACK = 3'b000,
        RGB_WHITE = 3'b111
    } rgb_e;

    localparam int unsigned BAR_COUNT = 8;

    // Bar 0 (leftmost) is white, bar 7 is black: entry i holds 7-i.
    localparam logic [3*BAR_COUNT-1:0] BAR_TABLE = {
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7
    };

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [4:0] base;
        base = 5'(idx) * 5'd3;
        return BAR_TABLE[base +: 3];
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (pixels or lines) spanning VIS+FP+SYNC+BP positions,
// with visible/sync window decodes of the current count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned VIS  = VGA_640X480_H_VIS,
    parameter int unsigned FP   = VGA_640X480_H_FP,
    parameter int unsigned SYNC = VGA_640X480_H_SYNC,
    parameter int unsigned BP   = VGA_640X480_H_BP,
    parameter logic        POL  = SYNC_ACTIVE_LOW,
    parameter int unsigned CW   = VGA_DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          vis,
    output logic          sync
);

    localparam int unsigned   TOTAL   = VIS + FP + SYNC + BP;
    localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
    localparam logic [CW-1:0] VIS_END = CW'(VIS);
    localparam logic [CW-1:0] SYNC_LO = CW'(VIS + FP);
    localparam logic [CW-1:0] SYNC_HI = CW'(VIS + FP + SYNC);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // wrap is not qualified by ce so the vertical axis can use it as its step.
    assign wrap = step && (cnt_q == LAST);
    assign vis  = (cnt_q < VIS_END);
    assign sync = ((cnt_q >= SYNC_LO) && (cnt_q < SYNC_HI)) ? POL : ~POL;
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (ce && step) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with registered sync/de/coordinates/strobes and frame counter.
// Define VGA_PATTERN_EN to add the registered border + colour-bar test pattern on rgb.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS      = VGA_640X480_H_VIS,
    parameter int unsigned H_FP       = VGA_640X480_H_FP,
    parameter int unsigned H_SYNC     = VGA_640X480_H_SYNC,
    parameter int unsigned H_BP       = VGA_640X480_H_BP,
    parameter int unsigned V_VIS      = VGA_640X480_V_VIS,
    parameter int unsigned V_FP       = VGA_640X480_V_FP,
    parameter int unsigned V_SYNC     = VGA_640X480_V_SYNC,
    parameter int unsigned V_BP       = VGA_640X480_V_BP,
    parameter logic        H_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter logic        V_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int unsigned CW         = VGA_DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt,
    output logic [2:0]    rgb
);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_vis;
    logic          v_vis;
    logic          h_sync;
    logic          v_sync;

    vga_axis_counter #(
        .VIS (H_VIS),
        .FP  (H_FP),
        .SYNC(H_SYNC),
        .BP  (H_BP),
        .POL (H_SYNC_POL),
        .CW  (CW)
    ) u_h_axis (
        .clk (clk),
        .rst (rst),
        .ce  (pix_ce),
        .step(1'b1),
        .cnt (h_cnt),
        .wrap(h_wrap),
        .vis (h_vis),
        .sync(h_sync)
    );

    vga_axis_counter #(
        .VIS (V_VIS),
        .FP  (V_FP),
        .SYNC(V_SYNC),
        .BP  (V_BP),
        .POL (V_SYNC_POL),
        .CW  (CW)
    ) u_v_axis (
        .clk (clk),
        .rst (rst),
        .ce  (pix_ce),
        .step(h_wrap),
        .cnt (v_cnt),
        .wrap(v_wrap),
        .vis (v_vis),
        .sync(v_sync)
    );

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          de_q, de_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          line_origin_q, line_origin_d;
    logic          frame_origin_q, frame_origin_d;
    logic          vis_now;

    assign vis_now = h_vis && v_vis;

    // The origin flags mark "counters sit at x==0 (and y==0)", set by reset and by each
    // wrap, so the strobes need no full-width compare against zero.
    always_comb begin
        x_d            = x_q;
        y_d            = y_q;
        de_d           = de_q;
        hsync_d        = hsync_q;
        vsync_d        = vsync_q;
        line_start_d   = line_start_q;
        frame_start_d  = frame_start_q;
        frame_cnt_d    = frame_cnt_q;
        line_origin_d  = line_origin_q;
        frame_origin_d = frame_origin_q;
        if (pix_ce) begin
            x_d            = h_cnt;
            y_d            = v_cnt;
            de_d           = vis_now;
            hsync_d        = h_sync;
            vsync_d        = v_sync;
            line_start_d   = line_origin_q;
            frame_start_d  = frame_origin_q;
            frame_cnt_d    = frame_cnt_q + {7'd0, frame_origin_q};
            line_origin_d  = h_wrap;
            frame_origin_d = v_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q            <= '0;
            y_q            <= '0;
            de_q           <= 1'b0;
            hsync_q        <= ~H_SYNC_POL;
            vsync_q        <= ~V_SYNC_POL;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_cnt_q    <= '0;
            line_origin_q  <= 1'b1;
            frame_origin_q <= 1'b1;
        end else begin
            x_q            <= x_d;
            y_q            <= y_d;
            de_q           <= de_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            frame_cnt_q    <= frame_cnt_d;
            line_origin_q  <= line_origin_d;
            frame_origin_q <= frame_origin_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

`ifdef VGA_PATTERN_EN
    localparam int unsigned BAR_W = H_VIS / BAR_COUNT;

    logic [2:0] rgb_q, rgb_d;
    logic [2:0] bar_idx;
    logic       border;

    always_comb begin
        bar_idx = '0;
        for (int unsigned i = 1; i < BAR_COUNT; i++) begin
            if (32'(h_cnt) >= i * BAR_W) begin
                bar_idx = 3'(i);
            end
        end
        border = (h_cnt == '0) || (h_cnt == CW'(H_VIS - 1)) ||
                 (v_cnt == '0) || (v_cnt == CW'(V_VIS - 1));
        rgb_d = rgb_q;
        if (pix_ce) begin
            if (!vis_now) begin
                rgb_d = RGB_BLACK;
            end else if (border) begin
                rgb_d = RGB_WHITE;
            end else begin
                rgb_d = bar_rgb(bar_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= RGB_BLACK;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;
`else
    assign rgb = '0;
`endif

endmodule
